// File: rtl/rx_uart.sv
`default_nettype none
// ============================================================================
//  Module      : rx_uart
//  Description : Oversampled UART receiver with a one-hot FSM, a two-flop input
//                synchronizer, framing-error and overrun reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_uart #(
    parameter int N_DATA      = 8,
    parameter int NB_STATE    = 4,
    parameter int DATA_TICKS  = 15,
    parameter int START_TICKS = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx,
    input  logic              s_tick,
    input  logic              rd_ack,
    output logic [N_DATA-1:0] dout,
    output logic              dout_valid,
    output logic              rx_done_tick,
    output logic              frame_error,
    output logic              overrun
);

    localparam int                 c_BIT_W    = (N_DATA > 1) ? $clog2(N_DATA) : 1;
    localparam logic [3:0]         c_START_T  = 4'(START_TICKS);
    localparam logic [3:0]         c_DATA_T   = 4'(DATA_TICKS);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(N_DATA - 1);

    typedef enum logic [NB_STATE-1:0] {
        IDLE  = NB_STATE'(1),
        START = NB_STATE'(2),
        DATA  = NB_STATE'(4),
        STOP  = NB_STATE'(8)
    } state_t;

    logic               r_rx_meta;
    logic               r_rx_s;
    state_t             r_state;
    state_t             w_state_next;
    logic [3:0]         r_tick_cnt;
    logic [3:0]         w_tick_cnt_next;
    logic [c_BIT_W-1:0] r_bit_cnt;
    logic [c_BIT_W-1:0] w_bit_cnt_next;
    logic [N_DATA-1:0]  r_shift;
    logic [N_DATA-1:0]  w_shift_next;
    logic               r_wait_high;
    logic               w_wait_high_next;
    logic               w_good_stop;
    logic               w_bad_stop;
    logic [N_DATA-1:0]  r_dout;
    logic               r_dout_valid;
    logic               r_done;
    logic               r_ferr;
    logic               r_overrun;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_wait_high <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_tick_cnt  <= w_tick_cnt_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_shift     <= w_shift_next;
            r_wait_high <= w_wait_high_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_tick_cnt_next  = r_tick_cnt;
        w_bit_cnt_next   = r_bit_cnt;
        w_shift_next     = r_shift;
        // After a framing error the line must be seen high before re-arming.
        w_wait_high_next = r_wait_high & ~r_rx_s;
        w_good_stop      = 1'b0;
        w_bad_stop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (s_tick && !r_rx_s && !r_wait_high) begin
                    w_state_next    = START;
                    w_tick_cnt_next = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (r_tick_cnt == c_START_T) begin
                        if (!r_rx_s) begin
                            w_state_next    = DATA;
                            w_tick_cnt_next = '0;
                            w_bit_cnt_next  = '0;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end else begin
                        w_tick_cnt_next = r_tick_cnt + 4'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (r_tick_cnt == c_DATA_T) begin
                        w_tick_cnt_next = '0;
                        w_shift_next    = {r_rx_s, r_shift[N_DATA-1:1]};
                        if (r_bit_cnt == c_LAST_BIT) begin
                            w_state_next   = STOP;
                            w_bit_cnt_next = '0;
                        end else begin
                            w_bit_cnt_next = r_bit_cnt + 1'b1;
                        end
                    end else begin
                        w_tick_cnt_next = r_tick_cnt + 4'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (r_tick_cnt == c_DATA_T) begin
                        w_state_next    = IDLE;
                        w_tick_cnt_next = '0;
                        if (r_rx_s) begin
                            w_good_stop = 1'b1;
                        end else begin
                            w_bad_stop       = 1'b1;
                            w_wait_high_next = 1'b1;
                        end
                    end else begin
                        w_tick_cnt_next = r_tick_cnt + 4'd1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_done       <= 1'b0;
            r_ferr       <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_done <= w_good_stop;
            r_ferr <= w_bad_stop;
            // A completing frame takes priority over a simultaneous acknowledge.
            if (w_good_stop) begin
                r_dout       <= r_shift;
                r_dout_valid <= 1'b1;
            end else if (rd_ack) begin
                r_dout_valid <= 1'b0;
            end
            if (rd_ack) begin
                r_overrun <= 1'b0;
            end else if (w_good_stop && r_dout_valid) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign dout         = r_dout;
    assign dout_valid   = r_dout_valid;
    assign rx_done_tick = r_done;
    assign frame_error  = r_ferr;
    assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_rx_uart.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rx_uart
//  Description : Self-checking bench for rx_uart against a frame-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_uart;

    logic       clock  = 1'b0;
    logic       reset  = 1'b1;
    logic       rx     = 1'b1;
    logic       s_tick = 1'b0;
    logic       rd_ack = 1'b0;
    logic [7:0] dout;
    logic       dout_valid;
    logic       rx_done_tick;
    logic       frame_error;
    logic       overrun;

    int total = 0;
    int bad   = 0;
    int tick_div = 4;
    int tcnt     = 0;

    int         done_cnt = 0;
    int         ferr_cnt = 0;
    logic [7:0] done_q[$];

    // Frame-level reference: what the consumer should see after each frame.
    logic [7:0] m_dout    = 8'h00;
    logic       m_valid   = 1'b0;
    logic       m_overrun = 1'b0;
    int         m_done    = 0;
    int         m_ferr    = 0;

    rx_uart #(
        .N_DATA      (8),
        .NB_STATE    (4),
        .DATA_TICKS  (15),
        .START_TICKS (7)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rx           (rx),
        .s_tick       (s_tick),
        .rd_ack       (rd_ack),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .rx_done_tick (rx_done_tick),
        .frame_error  (frame_error),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (tcnt >= tick_div - 1) begin
            tcnt   = 0;
            s_tick = 1'b1;
        end else begin
            tcnt   = tcnt + 1;
            s_tick = 1'b0;
        end
    end

    // Pulse monitor: a pulse held two clocks counts twice.
    always @(posedge clock) begin
        #2;
        if (rx_done_tick === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_q.push_back(dout);
        end
        if (frame_error === 1'b1) ferr_cnt = ferr_cnt + 1;
    end

    function automatic void model_frame(input logic [7:0] b, input logic stop);
        if (stop) begin
            if (m_valid) m_overrun = 1'b1;
            m_dout  = b;
            m_valid = 1'b1;
            m_done  = m_done + 1;
        end else begin
            m_ferr = m_ferr + 1;
        end
    endfunction

    function automatic void model_ack();
        m_valid   = 1'b0;
        m_overrun = 1'b0;
    endfunction

    function automatic void model_reset();
        m_dout    = 8'h00;
        m_valid   = 1'b0;
        m_overrun = 1'b0;
    endfunction

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (16 * tick_div) @(negedge clock);
    endtask

    task automatic send_data(input logic [7:0] b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_data(b);
        drive_bit(stop);
    endtask

    task automatic do_ack();
        rd_ack = 1'b1;
        @(negedge clock);
        rd_ack = 1'b0;
        model_ack();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        total++; if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout: got %h expected 00", dout); end
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", dout_valid); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        total++; if (rx_done_tick !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", rx_done_tick); end
        total++; if (frame_error !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b expected 0", frame_error); end
    endtask

    task automatic test_basic();
        tick_div = 4;
        repeat (2) drive_bit(1'b1);
        send_data(8'hA5);
        total++; if (done_cnt !== m_done) begin bad++; $display("FAIL basic_early_pulse: got %0d expected %0d", done_cnt, m_done); end
        drive_bit(1'b1);
        model_frame(8'hA5, 1'b1);
        total++; if (done_cnt !== m_done) begin bad++; $display("FAIL basic_done_cnt: got %0d expected %0d", done_cnt, m_done); end
        total++; if (dout !== 8'hA5) begin bad++; $display("FAIL basic_dout: got %h expected a5", dout); end
        total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b expected 1", dout_valid); end
        total++; if (ferr_cnt !== m_ferr) begin bad++; $display("FAIL basic_ferr: got %0d expected %0d", ferr_cnt, m_ferr); end
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        repeat (3 * tick_div) @(negedge clock);
        rx = 1'b1;
        repeat (20 * tick_div) @(negedge clock);
        total++; if (done_cnt !== m_done) begin bad++; $display("FAIL glitch_done: got %0d expected %0d", done_cnt, m_done); end
        total++; if (ferr_cnt !== m_ferr) begin bad++; $display("FAIL glitch_ferr: got %0d expected %0d", ferr_cnt, m_ferr); end
        send_frame(8'h3C, 1'b1);
        model_frame(8'h3C, 1'b1);
        drive_bit(1'b1);
        total++; if (dout !== 8'h3C) begin bad++; $display("FAIL glitch_next_dout: got %h expected 3c", dout); end
        total++; if (done_cnt !== m_done) begin bad++; $display("FAIL glitch_next_done: got %0d expected %0d", done_cnt, m_done); end
    endtask

    task automatic test_frame_error();
        send_frame(8'h5A, 1'b0);
        model_frame(8'h5A, 1'b0);
        repeat (2) drive_bit(1'b1);
        total++; if (ferr_cnt !== m_ferr) begin bad++; $display("FAIL ferr_cnt: got %0d expected %0d", ferr_cnt, m_ferr); end
        total++; if (dout !== m_dout) begin bad++; $display("FAIL ferr_dout: got %h expected %h", dout, m_dout); end
        total++; if (dout_valid !== m_valid) begin bad++; $display("FAIL ferr_valid: got %b expected %b", dout_valid, m_valid); end
        total++; if (done_cnt !== m_done) begin bad++; $display("FAIL ferr_done: got %0d expected %0d", done_cnt, m_done); end
    endtask

    task automatic test_overrun();
        do_ack();
        send_frame(8'h11, 1'b1);
        model_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        model_frame(8'h22, 1'b1);
        drive_bit(1'b1);
        total++; if (dout !== 8'h22) begin bad++; $display("FAIL ovr_dout: got %h expected 22", dout); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag: got %b expected 1", overrun); end
        total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid: got %b expected 1", dout_valid); end
        do_ack();
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL ovr_ack_valid: got %b expected 0", dout_valid); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_ack_flag: got %b expected 0", overrun); end
    endtask

    task automatic test_ack_collide();
        int  prev;
        logic seen;
        send_frame(8'h66, 1'b1);
        model_frame(8'h66, 1'b1);
        send_data(8'h99);
        prev = done_cnt;
        seen = 1'b0;
        rx   = 1'b1;
        for (int k = 0; k < 16 * tick_div; k++) begin
            rd_ack = ~seen;
            @(negedge clock);
            if (!seen && done_cnt != prev) begin
                seen = 1'b1;
                total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL collide_valid: got %b expected 1", dout_valid); end
            end
        end
        rd_ack = 1'b0;
        model_ack();
        model_frame(8'h99, 1'b1);
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL collide_pulse: got %b expected 1", seen); end
        total++; if (dout !== 8'h99) begin bad++; $display("FAIL collide_dout: got %h expected 99", dout); end
        total++; if (overrun !== m_overrun) begin bad++; $display("FAIL collide_overrun: got %b expected %b", overrun, m_overrun); end
    endtask

    task automatic test_reset_midframe();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rx = 1'b1;
        repeat (8 * tick_div) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_reset();
        repeat (8 * tick_div) @(negedge clock);
        for (int i = 5; i < 9; i++) drive_bit(1'b1);
        drive_bit(1'b1);
        total++; if (dout !== 8'h00) begin bad++; $display("FAIL rstmid_dout: got %h expected 00", dout); end
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b expected 0", dout_valid); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rstmid_overrun: got %b expected 0", overrun); end
        total++; if (done_cnt !== m_done) begin bad++; $display("FAIL rstmid_done: got %0d expected %0d", done_cnt, m_done); end
        total++; if (ferr_cnt !== m_ferr) begin bad++; $display("FAIL rstmid_ferr: got %0d expected %0d", ferr_cnt, m_ferr); end
        send_frame(8'h81, 1'b1);
        model_frame(8'h81, 1'b1);
        drive_bit(1'b1);
        total++; if (dout !== 8'h81) begin bad++; $display("FAIL rstmid_next_dout: got %h expected 81", dout); end
        total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL rstmid_next_valid: got %b expected 1", dout_valid); end
    endtask

    task automatic test_back_to_back();
        int base;
        do_ack();
        base = done_q.size();
        send_frame(8'h00, 1'b1);
        model_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        model_frame(8'hFF, 1'b1);
        drive_bit(1'b1);
        total++; if (done_cnt !== m_done) begin bad++; $display("FAIL b2b_done: got %0d expected %0d", done_cnt, m_done); end
        total++; if (ferr_cnt !== m_ferr) begin bad++; $display("FAIL b2b_ferr: got %0d expected %0d", ferr_cnt, m_ferr); end
        total++; if (done_q.size() !== base + 2) begin bad++; $display("FAIL b2b_count: got %0d expected %0d", done_q.size(), base + 2); end
        if (done_q.size() >= base + 2) begin
            total++; if (done_q[base] !== 8'h00) begin bad++; $display("FAIL b2b_first: got %h expected 00", done_q[base]); end
            total++; if (done_q[base + 1] !== 8'hFF) begin bad++; $display("FAIL b2b_second: got %h expected ff", done_q[base + 1]); end
        end
        total++; if (overrun !== m_overrun) begin bad++; $display("FAIL b2b_overrun: got %b expected %b", overrun, m_overrun); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       stop;
        for (int n = 0; n < 25; n++) begin
            tick_div = $urandom_range(2, 5);
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_frame(b, stop);
            model_frame(b, stop);
            if (!stop) drive_bit(1'b1);
            total++; if (dout !== m_dout) begin bad++; $display("FAIL rnd_dout[%0d]: got %h expected %h", n, dout, m_dout); end
            total++; if (dout_valid !== m_valid) begin bad++; $display("FAIL rnd_valid[%0d]: got %b expected %b", n, dout_valid, m_valid); end
            total++; if (overrun !== m_overrun) begin bad++; $display("FAIL rnd_overrun[%0d]: got %b expected %b", n, overrun, m_overrun); end
            total++; if (done_cnt !== m_done) begin bad++; $display("FAIL rnd_done[%0d]: got %0d expected %0d", n, done_cnt, m_done); end
            total++; if (ferr_cnt !== m_ferr) begin bad++; $display("FAIL rnd_ferr[%0d]: got %0d expected %0d", n, ferr_cnt, m_ferr); end
            if ($urandom_range(0, 1) == 1) begin
                do_ack();
                total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL rnd_ack_valid[%0d]: got %b expected 0", n, dout_valid); end
                total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rnd_ack_overrun[%0d]: got %b expected 0", n, overrun); end
            end
            repeat ($urandom_range(0, 2)) drive_bit(1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_ack_collide();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
